// File: rtl/poly_sub_reduce_stream_if.sv
// Stream bundle for poly_sub_reduce_stream.
// Carries the 16-bit-lane input stream, the 12-bit-lane output stream and their handshakes.
// The slave modport is the reducer's view; the master modport is the surrounding datapath's view.
interface poly_sub_reduce_stream_if #(
    parameter int COEFFS_PER_WORD = 8,
    parameter int i_Coeffs_Width  = COEFFS_PER_WORD * 16,
    parameter int o_Coeffs_Width  = COEFFS_PER_WORD * 12
);
    logic [i_Coeffs_Width-1:0] iCoeffs;
    logic                      iValid;
    logic                      oReady_in;
    logic [o_Coeffs_Width-1:0] oCoeffs;
    logic                      oValid;
    logic                      iReady_out;
    logic                      oLast;

    modport slave (
        input  iCoeffs, iValid, iReady_out,
        output oReady_in, oCoeffs, oValid, oLast
    );

    modport master (
        output iCoeffs, iValid, iReady_out,
        input  oReady_in, oCoeffs, oValid, oLast
    );
endinterface

// File: rtl/poly_sub_reduce_stream.sv
// poly_sub_reduce_stream: reduces signed 16-bit coefficient differences to [0, KYBER_Q-1]
// and repacks them as eight 12-bit lanes per word. Two-stage Barrett pipeline with a
// global stall, one polynomial (KYBER_N/COEFFS_PER_WORD words) per iStart.
module poly_sub_reduce_stream #(
    parameter int KYBER_N         = 256,
    parameter int KYBER_Q         = 3329,
    parameter int COEFFS_PER_WORD = 8,
    parameter int i_Coeffs_Width  = COEFFS_PER_WORD * 16,
    parameter int o_Coeffs_Width  = COEFFS_PER_WORD * 12
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           iStart,
    poly_sub_reduce_stream_if.slave        bus,
    output logic                           oBusy,
    output logic                           oDone
);
    localparam int WORDS  = KYBER_N / COEFFS_PER_WORD;
    localparam int CNT_W  = $clog2(WORDS + 1);
    localparam int OCNT_W = $clog2(WORDS);
    localparam logic [CNT_W-1:0]  ALL_IN    = CNT_W'(WORDS);
    localparam logic [CNT_W-1:0]  LAST_IN   = CNT_W'(WORDS - 1);
    localparam logic [OCNT_W-1:0] LAST_OUT  = OCNT_W'(WORDS - 1);
    localparam logic [17:0]       QW        = 18'(KYBER_Q);
    // floor(2^26 / 3329) rounded up; paired with a shift of 26
    localparam logic [31:0]       BARRETT_M = 32'd20159;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t                    r_state;
    logic [CNT_W-1:0]          r_in_cnt;
    logic [OCNT_W-1:0]         r_out_cnt;
    logic                      r_done;
    logic                      r_v1;
    logic [15:0]               r_x1 [COEFFS_PER_WORD];
    logic [5:0]                r_q1 [COEFFS_PER_WORD];
    logic                      r_valid;
    logic [o_Coeffs_Width-1:0] r_coeffs;

    logic [i_Coeffs_Width-1:0] w_in;
    logic                      w_en;
    logic                      w_acc;
    logic                      w_ohs;
    logic [5:0]                w_q [COEFFS_PER_WORD];
    logic [17:0]               w_r;
    logic [o_Coeffs_Width-1:0] w_red;

    assign w_in          = bus.iCoeffs;
    assign w_en          = !r_valid || bus.iReady_out;
    assign bus.oReady_in = (r_state == S_RUN) && (r_in_cnt < ALL_IN) && w_en;
    assign w_acc         = bus.iValid && bus.oReady_in;
    assign w_ohs         = r_valid && bus.iReady_out;
    assign bus.oValid    = r_valid;
    assign bus.oCoeffs   = r_coeffs;
    assign bus.oLast     = r_valid && (r_out_cnt == LAST_OUT);
    assign oBusy         = (r_state != S_IDLE);
    assign oDone         = r_done;

    // Stage-1 quotient estimate: q = (x * 20159) >>> 26, taken from the top six product bits
    always_comb begin
        for (int unsigned j = 0; j < COEFFS_PER_WORD; j++) begin
            w_q[j] = 6'(({{16{w_in[16*j+15]}}, w_in[16*j +: 16]} * BARRETT_M) >> 26);
        end
    end

    // Stage-2 remainder x - q*Q lies in [-Q, 2Q): negatives need +Q, exact
    // negative multiples of Q overshoot the quotient and land on Q, needing -Q
    always_comb begin
        w_r   = '0;
        w_red = '0;
        for (int unsigned j = 0; j < COEFFS_PER_WORD; j++) begin
            w_r = {{2{r_x1[j][15]}}, r_x1[j]} - ({{12{r_q1[j][5]}}, r_q1[j]} * QW);
            if (w_r[17]) begin
                w_red[12*j +: 12] = 12'(w_r + QW);
            end else if (w_r >= QW) begin
                w_red[12*j +: 12] = 12'(w_r - QW);
            end else begin
                w_red[12*j +: 12] = w_r[11:0];
            end
        end
    end

    // Two-stage datapath advancing together under the global enable
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1     <= 1'b0;
            r_valid  <= 1'b0;
            r_coeffs <= '0;
            for (int unsigned j = 0; j < COEFFS_PER_WORD; j++) begin
                r_x1[j] <= '0;
                r_q1[j] <= '0;
            end
        end else if (w_en) begin
            r_v1    <= w_acc;
            r_valid <= r_v1;
            if (w_acc) begin
                for (int unsigned j = 0; j < COEFFS_PER_WORD; j++) begin
                    r_x1[j] <= w_in[16*j +: 16];
                    r_q1[j] <= w_q[j];
                end
            end
            if (r_v1) begin
                r_coeffs <= w_red;
            end
        end
    end

    // Control FSM, word counters and registered completion pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_acc) begin
                r_in_cnt <= r_in_cnt + 1'b1;
            end
            if (w_ohs) begin
                r_out_cnt <= r_out_cnt + 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (iStart) begin
                        r_state   <= S_RUN;
                        r_in_cnt  <= '0;
                        r_out_cnt <= '0;
                    end
                end
                S_RUN: begin
                    if (w_acc && (r_in_cnt == LAST_IN)) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_ohs && bus.oLast) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/poly_sub_reduce_stream.md
Name: poly_sub_reduce_stream

Overview:
- Streaming stage directly downstream of the polynomial-subtract datapath.
- Consumes 128-bit words of eight signed 16-bit coefficient differences and reduces each coefficient to the canonical range [0, KYBER_Q-1].
- Emits 96-bit words of eight packed 12-bit coefficients, the format the rest of the datapath uses.
- Handles one polynomial (KYBER_N/8 words) per start, with valid/ready flow control on both sides and a completion pulse.

Parameters:
- KYBER_N, 256: coefficients per polynomial.
- KYBER_Q, 3329: modulus.
- COEFFS_PER_WORD, 8: coefficients per bus word.
- i_Coeffs_Width, 128: input word width (COEFFS_PER_WORD*16).
- o_Coeffs_Width, 96: output word width (COEFFS_PER_WORD*12).

Ports:
- clk  in  1  sole clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- iStart  in  1  one-cycle pulse; begins a polynomial; honoured only in IDLE.
- iCoeffs  in  i_Coeffs_Width  signed 16-bit coeff j at bits [16j+15:16j].
- iValid  in  1  iCoeffs valid.
- oReady_in  out  1  block accepts iCoeffs this cycle.
- oCoeffs  out  o_Coeffs_Width  reduced coeff j at bits [12j+11:12j].
- oValid  out  1  oCoeffs valid.
- iReady_out  in  1  downstream accepts oCoeffs.
- oLast  out  1  high with the final (word KYBER_N/8-1) output word.
- oBusy  out  1  high in RUN and DRAIN.
- oDone  out  1  one-cycle pulse when the last word has been accepted downstream.

Behaviour:
- Reset: while rst is high, on a rising edge everything clears.
  - State becomes IDLE; counters become 0; pipeline valid bits become 0.
  - oCoeffs, oValid, oLast, oBusy, oDone and oReady_in all read 0.
  - Reset mid-polynomial discards all in-flight data; no oDone is produced.
- Arithmetic: per coefficient, x is signed 16-bit; out = x mod KYBER_Q in [0, 3328] (mathematical modulo, never negative).
  - Required for all 65536 values of x.
  - Implementation: Barrett multiply by 20159, shift 26, conditional +Q correction, split across 2 pipeline stages.
  - Coefficient lanes are independent.
- Pipeline:
  - 2 register stages; latency 2 cycles from input handshake (iValid & oReady_in) to oValid when unstalled.
  - Global advance enable en = !oValid | iReady_out. When en=0 both stages hold data and valid bits.
  - Full throughput: one word per cycle when iValid and iReady_out are continuously high.
- oReady_in = (state==RUN) & (in_cnt < KYBER_N/8) & en. It is combinational from registered state and iReady_out.
- Counters:
  - in_cnt, 0..32, counts accepted input words.
  - out_cnt, 0..31, counts accepted output words (oValid & iReady_out) and wraps to 0 after the last word.
- oLast = oValid & (out_cnt == KYBER_N/8-1).
- FSM:
  - IDLE: iStart -> RUN, clearing in_cnt and out_cnt. oReady_in is 0 in the iStart cycle, so data arriving with iStart is not taken.
  - RUN: when in_cnt reaches 32 -> DRAIN. Output handshakes continue throughout.
  - DRAIN: oReady_in=0. Handshake of the oLast word -> IDLE and oDone=1 (registered, asserted in the cycle after that handshake, for exactly one cycle).
  - iStart in RUN or DRAIN is ignored.
- Output stability: while oValid=1 and iReady_out=0, oCoeffs, oValid and oLast hold constant.
- Output ordering equals input ordering. No words are dropped or duplicated under any iValid/iReady_out pattern.

Test Plan:
- Reset then idle: rst held 3 cycles -> all outputs 0. iValid=1 with no iStart -> oReady_in stays 0, nothing emitted.
- Boundary values in one word, lanes 0..7 = 0, -1, 3329, -3329, 32767, -32768, 6658, 3328 -> oCoeffs lanes 0, 3328, 0, 0, 2806, 522, 0, 3328, with oValid exactly 2 cycles after accept.
- Full polynomial, iValid and iReady_out held 1, word k lanes = k*8+j -> 32 output words, lane value (k*8+j) mod 3329.
  - oLast only on word 31.
  - oDone one cycle after the word-31 handshake.
  - Total 34 cycles from first accept to oDone.
- Backpressure: iReady_out randomly low (50%), iValid randomly low -> output stream identical to the unstalled run and oCoeffs stable while stalled. oReady_in drops the same cycle iReady_out drops with oValid=1.
- Reset mid-operation: assert rst after word 10 accepted -> next cycle oValid=0 and oBusy=0; no oDone. A following iStart runs a clean 32-word polynomial.
- Exhaustive arithmetic: sweep x over -32768..32767, 8 lanes per word -> every lane equals a reference x mod 3329. A second iStart during RUN has no effect on counts.
